// File: rtl/case_match_pkg.sv
// ----------------------------------------------------------------------------
// case_match_pkg
//   Shared types and helpers for the programmable case-match unit.
//   - cm_item_t : one programmable case item {en, pat, mask, val}. Fields are
//                 sized to CM_MAX_W. Each user stores zero-extended values, so
//                 the constant upper bits are removed by synthesis.
//   - cm_idx_w  : clog2-based item-index width, never narrower than 1 bit.
//   Macro CASE_MATCH_MASK_EN: when defined, items carry a care mask
//   (casez-style wildcards). Otherwise items have no mask field.
// ----------------------------------------------------------------------------
package case_match_pkg;

  // Widest selector / result supported by the item record.
  localparam int CM_MAX_W = 32;

  typedef struct packed {
    logic                en;
    logic [CM_MAX_W-1:0] pat;
`ifdef CASE_MATCH_MASK_EN
    logic [CM_MAX_W-1:0] mask;   // 1 = compare this bit
`endif
    logic [CM_MAX_W-1:0] val;
  } cm_item_t;

  function automatic int cm_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/case_match_prio.sv
// ----------------------------------------------------------------------------
// case_match_prio
//   Combinational priority resolver: the lowest set bit of the match vector
//   wins.
//   Ports:
//     i_match [NUM_ITEMS]  per-item match flags
//     o_hit                any item matched
//     o_idx   [idx_w]      index of the lowest matching item (0 when no hit)
// ----------------------------------------------------------------------------
module case_match_prio
  import case_match_pkg::*;
#(
  parameter int NUM_ITEMS = 8
) (
  input  logic [NUM_ITEMS-1:0]             i_match,
  output logic                             o_hit,
  output logic [cm_idx_w(NUM_ITEMS)-1:0]   o_idx
);

  localparam int IDX_W = cm_idx_w(NUM_ITEMS);

  // NOTE: every output of an always_comb is given a default before any
  // conditional assignment, so no path leaves it unassigned (no latch).
  always_comb begin
    o_hit = |i_match;
    o_idx = '0;
    // Scan from the top down so the lowest matching index is written last.
    for (int k = NUM_ITEMS - 1; k >= 0; k--) begin
      if (i_match[k]) o_idx = IDX_W'(k);
    end
  end

endmodule

// File: rtl/case_match_unit.sv
// ----------------------------------------------------------------------------
// case_match_unit
//   Runtime-programmable case statement. NUM_ITEMS items {en, pat, mask, val}
//   are matched against in_sel. The lowest matching index wins. The result is
//   registered with a latency of one cycle behind a valid/ready handshake, and
//   misses are counted in a saturating counter.
//   Macro CASE_MATCH_MASK_EN: when defined, per-item care masks act as
//   wildcards. When undefined, cfg_mask is ignored and the compare is exact.
//   IN_W and OUT_W must not exceed case_match_pkg::CM_MAX_W.
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     in_valid/in_ready/in_sel        lookup request
//     out_valid/out_ready             result handshake
//     out_data/out_hit/out_idx        result value, hit flag, matching item
//     cfg_we/cfg_idx/cfg_en/cfg_pat/
//     cfg_mask/cfg_val                item write port (out-of-range ignored)
//     miss_cnt                        saturating count of missed lookups
// ----------------------------------------------------------------------------
module case_match_unit
  import case_match_pkg::*;
#(
  parameter int               IN_W        = 4,
  parameter int               OUT_W       = 1,
  parameter int               NUM_ITEMS   = 8,
  parameter logic [OUT_W-1:0] DEFAULT_VAL = '0,
  parameter int               CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_W-1:0]                in_sel,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_W-1:0]               out_data,
  output logic                           out_hit,
  output logic [cm_idx_w(NUM_ITEMS)-1:0] out_idx,
  input  logic                           cfg_we,
  input  logic [cm_idx_w(NUM_ITEMS)-1:0] cfg_idx,
  input  logic                           cfg_en,
  input  logic [IN_W-1:0]                cfg_pat,
  input  logic [IN_W-1:0]                cfg_mask,
  input  logic [OUT_W-1:0]               cfg_val,
  output logic [CNT_W-1:0]               miss_cnt
);

  localparam int IDX_W = cm_idx_w(NUM_ITEMS);

  cm_item_t               r_items [NUM_ITEMS];
  logic                   r_out_valid;
  logic [OUT_W-1:0]       r_out_data;
  logic                   r_out_hit;
  logic [IDX_W-1:0]       r_out_idx;
  logic [CNT_W-1:0]       r_miss_cnt;

  logic [CM_MAX_W-1:0]    w_sel_ext;
  logic [NUM_ITEMS-1:0]   w_match;
  logic                   w_hit;
  logic [IDX_W-1:0]       w_idx;
  logic [CM_MAX_W-1:0]    w_hit_val;
  logic                   w_accept;
  logic                   w_unused_val_hi;

  // Ready depends only on the output register state, never on in_valid.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  assign w_sel_ext = CM_MAX_W'(in_sel);

  // Per-item match. It reads the registered table, so a write in the same
  // cycle as a lookup only affects later lookups.
  always_comb begin
    for (int k = 0; k < NUM_ITEMS; k++) begin
`ifdef CASE_MATCH_MASK_EN
      w_match[k] = r_items[k].en &&
                   (((w_sel_ext ^ r_items[k].pat) & r_items[k].mask) == '0);
`else
      w_match[k] = r_items[k].en && (w_sel_ext == r_items[k].pat);
`endif
    end
  end

`ifndef CASE_MATCH_MASK_EN
  logic w_unused_mask;
  assign w_unused_mask = ^cfg_mask;
`endif

  case_match_prio #(
    .NUM_ITEMS (NUM_ITEMS)
  ) u_prio (
    .i_match (w_match),
    .o_hit   (w_hit),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_hit_val = '0;
    for (int k = 0; k < NUM_ITEMS; k++) begin
      if (w_idx == IDX_W'(k)) w_hit_val = r_items[k].val;
    end
  end

  // Bits above OUT_W are always zero, because values are stored zero-extended.
  assign w_unused_val_hi = |(w_hit_val >> OUT_W);

  // Item table. Writes to an index >= NUM_ITEMS match no k and are dropped.
  // NOTE: the table is reset like any other state. A cleared en bit must hold
  // from power-up, otherwise stale items could match before software runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_ITEMS; k++) r_items[k] <= '0;
    end else if (cfg_we) begin
      for (int k = 0; k < NUM_ITEMS; k++) begin
        if (cfg_idx == IDX_W'(k)) begin
          r_items[k].en   <= cfg_en;
          r_items[k].pat  <= CM_MAX_W'(cfg_pat);
`ifdef CASE_MATCH_MASK_EN
          r_items[k].mask <= CM_MAX_W'(cfg_mask);
`endif
          r_items[k].val  <= CM_MAX_W'(cfg_val);
        end
      end
    end
  end

  // Output register and miss counter.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= DEFAULT_VAL;
      r_out_hit   <= 1'b0;
      r_out_idx   <= '0;
      r_miss_cnt  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_hit   <= w_hit;
      r_out_idx   <= w_hit ? w_idx : '0;
      r_out_data  <= w_hit ? w_hit_val[OUT_W-1:0] : DEFAULT_VAL;
      if (!w_hit && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_hit   = r_out_hit;
  assign out_idx   = r_out_idx;
  assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_case_match_unit.sv
// ----------------------------------------------------------------------------
// tb_case_match_unit
//   Directed bench for case_match_unit. It uses NUM_ITEMS=6 (so cfg_idx can
//   address a non-existent item), OUT_W=2, DEFAULT_VAL=2'b10 and CNT_W=2.
//   Expected values follow CASE_MATCH_MASK_EN where masking changes them.
// ----------------------------------------------------------------------------
module tb_case_match_unit;

  localparam int               IN_W      = 4;
  localparam int               OUT_W     = 2;
  localparam int               NUM_ITEMS = 6;
  localparam int               CNT_W     = 2;
  localparam int               IDX_W     = 3;
  localparam logic [OUT_W-1:0] DEF       = 2'b10;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_sel;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_hit;
  logic [IDX_W-1:0] out_idx;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic             cfg_en;
  logic [IN_W-1:0]  cfg_pat;
  logic [IN_W-1:0]  cfg_mask;
  logic [OUT_W-1:0] cfg_val;
  logic [CNT_W-1:0] miss_cnt;

  int checks   = 0;
  int failures = 0;

  case_match_unit #(
    .IN_W        (IN_W),
    .OUT_W       (OUT_W),
    .NUM_ITEMS   (NUM_ITEMS),
    .DEFAULT_VAL (DEF),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_hit   (out_hit),
    .out_idx   (out_idx),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_en    (cfg_en),
    .cfg_pat   (cfg_pat),
    .cfg_mask  (cfg_mask),
    .cfg_val   (cfg_val),
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [IDX_W-1:0] idx, input logic en,
                           input logic [IN_W-1:0] pat, input logic [IN_W-1:0] mask,
                           input logic [OUT_W-1:0] val);
    cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_pat = pat; cfg_mask = mask; cfg_val = val;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic lookup(input logic [IN_W-1:0] sel);
    in_sel    = sel;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic hit,
                            input logic [IDX_W-1:0] idx, input logic [OUT_W-1:0] data);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_hit"},   out_hit,   hit);
    check({tag, "_idx"},   out_idx,   idx);
    check({tag, "_data"},  out_data,  data);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_pat = '0; cfg_mask = '0; cfg_val = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data",  out_data,  DEF);
    check("rst_out_hit",   out_hit,   1'b0);
    check("rst_out_idx",   out_idx,   3'd0);
    check("rst_miss_cnt",  miss_cnt,  2'd0);
    rst_n = 1'b1;
    step();

    // Empty table: every lookup misses
    lookup(4'b0110);
    expect_res("empty", 1'b0, 3'd0, DEF);
    check("empty_miss_cnt", miss_cnt, 2'd1);
    step();
    check("drain_out_valid", out_valid, 1'b0);

    // Priority between overlapping items
    cfg_write(3'd0, 1'b1, 4'b0110, 4'b1110, 2'd1);
    cfg_write(3'd3, 1'b1, 4'b0111, 4'b1111, 2'd0);
    lookup(4'b0111);
`ifdef CASE_MATCH_MASK_EN
    expect_res("prio", 1'b1, 3'd0, 2'd1);
`else
    expect_res("prio", 1'b1, 3'd3, 2'd0);
`endif
    lookup(4'b0110);
    expect_res("exact0", 1'b1, 3'd0, 2'd1);
    check("prio_miss_cnt", miss_cnt, 2'd1);

    // A write to a non-existent item is dropped
    cfg_write(3'd7, 1'b1, 4'b1111, 4'b1111, 2'd3);
    lookup(4'b1111);
    expect_res("oob", 1'b0, 3'd0, DEF);
    check("oob_miss_cnt", miss_cnt, 2'd2);

    // Backpressure: hold for 3 cycles, then one transfer per cycle
    in_sel = 4'b0110; in_valid = 1'b1; out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_sel = 4'b1111;
    // A write during the hold must not disturb the held result
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_en = 1'b1; cfg_pat = 4'b0110; cfg_mask = 4'b1110; cfg_val = 2'd0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_in_ready", in_ready, 1'b0);
      expect_res("bp_hold", 1'b1, 3'd0, 2'd1);
      step();
      cfg_we = 1'b0;
    end
    #1;
    check("bp_in_ready_last", in_ready, 1'b0);
    expect_res("bp_hold_last", 1'b1, 3'd0, 2'd1);
    // Restore item0 val=1 while the queued 1111 lookup is accepted
    out_ready = 1'b1;
    cfg_we = 1'b1; cfg_val = 2'd1;
    #1;
    check("bp_release_ready", in_ready, 1'b1);
    step();
    cfg_we = 1'b0;
    expect_res("bp_xfer1", 1'b0, 3'd0, DEF);
    check("bp_miss_cnt", miss_cnt, 2'd3);
    in_sel = 4'b0110;
    step();
    expect_res("bp_xfer2", 1'b1, 3'd0, 2'd1);
    in_valid = 1'b0;
    step();
    check("bp_drained", out_valid, 1'b0);

    // A write in the same cycle as a lookup: the lookup sees the old table
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_en = 1'b1; cfg_pat = 4'b0110; cfg_mask = 4'b1110; cfg_val = 2'd0;
    in_sel = 4'b0110; in_valid = 1'b1; out_ready = 1'b1;
    step();
    cfg_we = 1'b0; in_valid = 1'b0;
    expect_res("coll_old", 1'b1, 3'd0, 2'd1);
    lookup(4'b0110);
    expect_res("coll_new", 1'b1, 3'd0, 2'd0);

    // Zero mask: wildcard match only when masking is compiled in
    cfg_write(3'd0, 1'b1, 4'b0110, 4'b0000, 2'd1);
    lookup(4'b0001);
`ifdef CASE_MATCH_MASK_EN
    expect_res("mask0", 1'b1, 3'd0, 2'd1);
`else
    expect_res("mask0", 1'b0, 3'd0, DEF);
`endif

    // All items disabled
    cfg_write(3'd0, 1'b0, 4'b0110, 4'b0000, 2'd1);
    cfg_write(3'd3, 1'b0, 4'b0111, 4'b1111, 2'd0);
    lookup(4'b0111);
    expect_res("disabled", 1'b0, 3'd0, DEF);

    // Reset discards a held result
    in_sel = 4'b0000; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("held_before_rst", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_held_valid",  out_valid, 1'b0);
    check("rst_held_ready",  in_ready,  1'b1);
    check("rst_held_miss",   miss_cnt,  2'd0);
    check("rst_held_data",   out_data,  DEF);
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    step();

    // Miss counter saturates at all-ones
    for (int m = 1; m <= 5; m++) begin
      lookup(4'b0110);
      check($sformatf("sat_miss_%0d", m), miss_cnt, (m < 3) ? m : 3);
    end
    check("sat_hit", out_hit, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
